// File: rtl/i2c_slave_byte_ctrl.sv
// I2C slave byte controller: START/STOP detection, 7-bit address match,
// byte receive with host-selected ACK, byte transmit with optional SCL stretching.
module i2c_slave_byte_ctrl #(
  parameter logic STRETCH_EN = 1'b1
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       ena,
  input  logic [6:0] slave_addr,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oen,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  input  logic       ack_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       ack_out,
  output logic       busy,
  output logic       addressed
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_WAIT, TX, TX_ACK
  } state_t;

  state_t      state_q, state_d;
  logic        scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_p_q, scl_p_d;
  logic        sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_p_q, sda_p_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic        slot_q, slot_d;
  logic        sda_oen_q, sda_oen_d;
  logic        scl_oen_q, scl_oen_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_pend_q, rx_pend_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_req_q, tx_req_d;
  logic        ack_out_q, ack_out_d;
  logic        ack_hold_q, ack_hold_d;
  logic        busy_q, busy_d;
  logic        addressed_q, addressed_d;

  logic        scl_rise, scl_fall, start_det, stop_det, last_bit;
  logic [7:0]  byte_in;

  assign scl_rise  = scl_s2_q & ~scl_p_q;
  assign scl_fall  = ~scl_s2_q & scl_p_q;
  assign start_det = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
  // Counter starts at 0 and wraps through 7..1, so the eighth bit is seen at 1.
  assign last_bit  = (cnt_q == 3'd1);
  assign byte_in   = {shift_q, sda_s2_q};

  always_comb begin
    scl_s1_d    = scl_i;
    scl_s2_d    = scl_s1_q;
    scl_p_d     = scl_s2_q;
    sda_s1_d    = sda_i;
    sda_s2_d    = sda_s1_q;
    sda_p_d     = sda_s2_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    slot_d      = slot_q;
    sda_oen_d   = sda_oen_q;
    scl_oen_d   = scl_oen_q;
    rx_data_d   = rx_data_q;
    rx_pend_d   = 1'b0;
    rx_valid_d  = rx_pend_q;
    tx_req_d    = 1'b0;
    ack_out_d   = ack_out_q;
    ack_hold_d  = rx_valid_q ? ack_in : ack_hold_q;
    busy_d      = busy_q;
    addressed_d = addressed_q;

    if (!ena) begin
      state_d     = IDLE;
      cnt_d       = 3'd0;
      slot_d      = 1'b0;
      sda_oen_d   = 1'b1;
      scl_oen_d   = 1'b1;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
    end else if (start_det) begin
      state_d     = ADDR;
      cnt_d       = 3'd0;
      slot_d      = 1'b0;
      sda_oen_d   = 1'b1;
      scl_oen_d   = 1'b1;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
    end else if (stop_det) begin
      state_d     = IDLE;
      cnt_d       = 3'd0;
      slot_d      = 1'b0;
      sda_oen_d   = 1'b1;
      scl_oen_d   = 1'b1;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oen_d = 1'b1;
          scl_oen_d = 1'b1;
        end
        ADDR: begin
          if (scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q - 3'd1;
            if (last_bit) begin
              if (shift_q == slave_addr) begin
                rw_d        = sda_s2_q;
                addressed_d = 1'b1;
                slot_d      = 1'b0;
                state_d     = ADDR_ACK;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        ADDR_ACK: begin
          // First falling edge opens the ACK slot, the second one closes it.
          if (scl_fall) begin
            if (!slot_q) begin
              sda_oen_d = 1'b0;
              slot_d    = 1'b1;
            end else begin
              sda_oen_d = 1'b1;
              slot_d    = 1'b0;
              if (rw_q) begin
                tx_req_d  = 1'b1;
                scl_oen_d = ~STRETCH_EN;
                state_d   = TX_WAIT;
              end else begin
                state_d = RX;
              end
            end
          end
        end
        RX: begin
          if (scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q - 3'd1;
            if (last_bit) begin
              rx_data_d = byte_in;
              rx_pend_d = 1'b1;
              slot_d    = 1'b0;
              state_d   = RX_ACK;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            if (!slot_q) begin
              sda_oen_d = ack_hold_q;
              slot_d    = 1'b1;
            end else begin
              sda_oen_d = 1'b1;
              slot_d    = 1'b0;
              state_d   = RX;
            end
          end
        end
        TX_WAIT: begin
          // SCL stays stretched through the load cycle and is released from TX.
          scl_oen_d = ~STRETCH_EN;
          if (tx_load) begin
            shift_d   = tx_data[6:0];
            sda_oen_d = tx_data[7];
            cnt_d     = 3'd0;
            state_d   = TX;
          end
        end
        TX: begin
          scl_oen_d = 1'b1;
          if (scl_fall) begin
            cnt_d = cnt_q - 3'd1;
            if (last_bit) begin
              sda_oen_d = 1'b1;
              slot_d    = 1'b0;
              state_d   = TX_ACK;
            end else begin
              sda_oen_d = shift_q[6];
              shift_d   = {shift_q[5:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          if (!slot_q && scl_rise) begin
            ack_out_d = sda_s2_q;
            slot_d    = 1'b1;
          end else if (slot_q && scl_fall) begin
            slot_d = 1'b0;
            if (!ack_out_q) begin
              tx_req_d  = 1'b1;
              scl_oen_d = ~STRETCH_EN;
              state_d   = TX_WAIT;
            end else begin
              addressed_d = 1'b0;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_p_q     <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_p_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= 7'd0;
      rw_q        <= 1'b0;
      slot_q      <= 1'b0;
      sda_oen_q   <= 1'b1;
      scl_oen_q   <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_pend_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      ack_out_q   <= 1'b0;
      ack_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
    end else begin
      scl_s1_q    <= scl_s1_d;
      scl_s2_q    <= scl_s2_d;
      scl_p_q     <= scl_p_d;
      sda_s1_q    <= sda_s1_d;
      sda_s2_q    <= sda_s2_d;
      sda_p_q     <= sda_p_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      slot_q      <= slot_d;
      sda_oen_q   <= sda_oen_d;
      scl_oen_q   <= scl_oen_d;
      rx_data_q   <= rx_data_d;
      rx_pend_q   <= rx_pend_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      ack_out_q   <= ack_out_d;
      ack_hold_q  <= ack_hold_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
    end
  end

  assign scl_o     = 1'b0;
  assign sda_o     = 1'b0;
  assign scl_oen   = scl_oen_q;
  assign sda_oen   = sda_oen_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign ack_out   = ack_out_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;

endmodule
